ysyx_23060187_core_seq: RTL

Multi-cycle sequencer for the NPC datapath. It replaces the free-running, always-enabled single-cycle flow with an explicit FSM: fetch over a valid/ready instruction bus, decode/execute, optional load/store bus access, then writeback. It generates the PC-register and register-file write enables, and it halts on ebreak. It also detects bus errors and timeouts.

---
 rtl/ysyx_23060187_core_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060187_core_seq.sv
// Multi-cycle NPC sequencer: fetch, execute, optional load/store, writeback.
// Halts on ebreak. Bus errors and wait-state timeouts raise a sticky fault.
// Ports:
//   clk, rst               core clock, asynchronous active-low reset
//   ifu_req_*, ifu_rsp_*   instruction fetch valid/ready bus
//   inst                   latched instruction for the decoder
//   is_load/store/ebreak   decoder classification, sampled at the end of EXEC
//   lsu_req_*, lsu_rsp_*   data access valid/ready handshake
//   rf_wen, pc_we          writeback enables
//   halt, fault,
//   fault_cause            terminal status (01 fetch err, 10 lsu err, 11 timeout)
//   instret                retired instruction count
//   state                  current FSM state, for debug
module ysyx_23060187_core_seq #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   input  logic        ifu_rsp_valid,
   input  logic        ifu_rsp_err,
   output logic        ifu_rsp_ready,
   input  logic [31:0] ifu_rsp_data,
   output logic [31:0] inst,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_ebreak,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   input  logic        lsu_rsp_valid,
   input  logic        lsu_rsp_err,
   output logic        lsu_rsp_ready,
   output logic        rf_wen,
   output logic        pc_we,
   output logic        halt,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] instret,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FREQ  = 3'd1,
      S_FWAIT = 3'd2,
      S_EXEC  = 3'd3,
      S_MREQ  = 3'd4,
      S_MWAIT = 3'd5,
      S_WB    = 3'd6,
      S_STOP  = 3'd7
   } state_t;

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic             store_q;
   logic             store_nxt;
   logic             tmo;
   logic             halt_set;
   logic             fault_set;
   logic [1:0]       cause_set;

   assign tmo   = (cnt == CNT_W'(TIMEOUT));
   assign state = cur;

   // Next state, store flag and terminal-status decisions
   always_comb begin
      nxt       = cur;
      store_nxt = store_q;
      halt_set  = 1'b0;
      fault_set = 1'b0;
      cause_set = 2'b00;
      case (cur)
         S_IDLE: nxt = S_FREQ;
         S_FREQ: if (ifu_req_ready) nxt = S_FWAIT;
         S_FWAIT: begin
            if (ifu_rsp_valid) begin
               if (ifu_rsp_err) begin
                  nxt       = S_STOP;
                  fault_set = 1'b1;
                  cause_set = 2'b01;
               end else begin
                  nxt = S_EXEC;
               end
            end else if (tmo) begin
               nxt       = S_STOP;
               fault_set = 1'b1;
               cause_set = 2'b11;
            end
         end
         S_EXEC: begin
            // ebreak outranks any load/store classification
            if (is_ebreak) begin
               nxt      = S_STOP;
               halt_set = 1'b1;
            end else if (is_load || is_store) begin
               nxt       = S_MREQ;
               store_nxt = is_store;
            end else begin
               nxt       = S_WB;
               store_nxt = 1'b0;
            end
         end
         S_MREQ: if (lsu_req_ready) nxt = S_MWAIT;
         S_MWAIT: begin
            if (lsu_rsp_valid) begin
               if (lsu_rsp_err) begin
                  nxt       = S_STOP;
                  fault_set = 1'b1;
                  cause_set = 2'b10;
               end else begin
                  nxt = S_WB;
               end
            end else if (tmo) begin
               nxt       = S_STOP;
               fault_set = 1'b1;
               cause_set = 2'b11;
            end
         end
         S_WB:    nxt = S_FREQ;
         S_STOP:  nxt = S_STOP;
         default: nxt = S_IDLE;
      endcase
   end

   // State, datapath registers, and outputs decoded ahead from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur           <= S_IDLE;
         cnt           <= '0;
         store_q       <= 1'b0;
         inst          <= '0;
         instret       <= '0;
         halt          <= 1'b0;
         fault         <= 1'b0;
         fault_cause   <= 2'b00;
         ifu_req_valid <= 1'b0;
         ifu_rsp_ready <= 1'b0;
         lsu_req_valid <= 1'b0;
         lsu_rsp_ready <= 1'b0;
         pc_we         <= 1'b0;
         rf_wen        <= 1'b0;
      end else begin
         cur     <= nxt;
         store_q <= store_nxt;
         // Counts cycles of a wait state without a response; zero on entry
         if ((nxt == cur) && ((cur == S_FWAIT) || (cur == S_MWAIT)))
            cnt <= cnt + CNT_W'(1);
         else
            cnt <= '0;
         if ((cur == S_FWAIT) && ifu_rsp_valid && !ifu_rsp_err)
            inst <= ifu_rsp_data;
         if (cur == S_WB)
            instret <= instret + 32'd1;
         if (halt_set)
            halt <= 1'b1;
         if (fault_set) begin
            fault       <= 1'b1;
            fault_cause <= cause_set;
         end
         ifu_req_valid <= (nxt == S_FREQ);
         ifu_rsp_ready <= (nxt == S_FWAIT);
         lsu_req_valid <= (nxt == S_MREQ);
         lsu_rsp_ready <= (nxt == S_MWAIT);
         pc_we         <= (nxt == S_WB);
         rf_wen        <= (nxt == S_WB) && !store_nxt;
      end
   end

endmodule
